// File: rtl/tt_ternary_pkg.sv
// Shared widths, ternary weight encodings, FSM state type and the ternary
// term helper used by the matrix-vector stage and its column accumulators.
package tt_ternary_pkg;

  localparam int MAX_IN_LEN  = 16;
  localparam int MAX_OUT_LEN = 8;
  localparam int ACT_W       = 8;
  localparam int IN_IDX_W    = $clog2(MAX_IN_LEN);
  localparam int OUT_IDX_W   = $clog2(MAX_OUT_LEN);
  // One sign bit of headroom beyond the worst-case sum of MAX_IN_LEN activations.
  localparam int ACC_W       = ACT_W + IN_IDX_W + 1;

  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;
  localparam logic [1:0] TERN_ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Signed contribution of one weight/activation pair, already at accumulator width.
  // 2'b10 is unused by the loader and decodes as zero, same as 2'b00.
  function automatic logic signed [ACC_W-1:0] tern_term(input logic [1:0] w,
                                                        input logic signed [ACT_W-1:0] x);
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] term;
    x_ext = {{(ACC_W-ACT_W){x[ACT_W-1]}}, x};
    case (w)
      TERN_POS: term = x_ext;
      TERN_NEG: term = -x_ext;
      default:  term = {ACC_W{1'b0}};
    endcase
    return term;
  endfunction

endpackage

// File: rtl/tt_um_matvec_if.sv
// Activation input and result output handshakes of the matrix-vector stage.
// slave: the stage itself; master: whatever feeds activations and takes results.
interface tt_um_matvec_if;
  import tt_ternary_pkg::*;

  logic signed [ACT_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/tt_ternary_acc.sv
// One column accumulator: adds, subtracts or skips the current activation
// according to its ternary weight. Clear has priority over a concurrent beat.
module tt_ternary_acc
  import tt_ternary_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [1:0]              w,
  input  logic signed [ACT_W-1:0] x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_r;

  // Running column sum, cleared between vectors and on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc_r <= acc_r + tern_term(w, x);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/tt_um_matvec.sv
// Ternary matrix-vector stage. Reads the loader's weight array, accumulates
// y[j] = sum_i w[i][j]*x[i] over one vector of activations, then streams the
// selected results out one per handshake. All handshake outputs are registers.
module tt_um_matvec
  import tt_ternary_pkg::*;
(
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          ena,
  input  logic                                          w_done,
  input  logic [MAX_IN_LEN-1:0][MAX_OUT_LEN-1:0][1:0]  weights,
  input  logic [IN_IDX_W-1:0]                           in_len_m1,
  input  logic [OUT_IDX_W-1:0]                          out_len_m1,
  tt_um_matvec_if.slave                                 bus
);

  localparam logic [IN_IDX_W-1:0]  IN_ZERO  = {IN_IDX_W{1'b0}};
  localparam logic [IN_IDX_W-1:0]  IN_ONE   = {{(IN_IDX_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_IDX_W-1:0] OUT_ZERO = {OUT_IDX_W{1'b0}};
  localparam logic [OUT_IDX_W-1:0] OUT_ONE  = {{(OUT_IDX_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_t                  state_r;
  logic                    w_ok_r;
  logic [IN_IDX_W-1:0]     in_idx_r;
  logic [IN_IDX_W-1:0]     len_in_r;
  logic [OUT_IDX_W-1:0]    out_idx_r;
  logic [OUT_IDX_W-1:0]    len_out_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic signed [ACC_W-1:0] out_data_r;

  logic signed [ACC_W-1:0] acc_s [MAX_OUT_LEN];
  logic                    beat_s;
  logic                    out_fire_s;
  logic                    out_end_s;
  logic                    abort_s;
  logic                    clr_s;
  logic                    acc_en_s;
  logic                    in_end_s;
  logic [IN_IDX_W-1:0]     len_in_s;
  logic [OUT_IDX_W-1:0]    len_out_s;
  logic [OUT_IDX_W-1:0]    next_out_idx_s;
  logic signed [ACC_W-1:0] first_sum_s;

  // Lengths are taken straight from the ports on the first beat (when they
  // are also being latched) so a single-beat vector ends correctly.
  assign len_in_s   = (in_idx_r == IN_ZERO) ? in_len_m1  : len_in_r;
  assign len_out_s  = (in_idx_r == IN_ZERO) ? out_len_m1 : len_out_r;

  assign beat_s     = (state_r == ACCUM) && in_ready_r && bus.in_valid;
  assign in_end_s   = beat_s && (in_idx_r == len_in_s);
  assign out_fire_s = (state_r == DRAIN) && out_valid_r && bus.out_ready;
  assign out_end_s  = out_fire_s && (out_idx_r == len_out_r);
  assign abort_s    = !ena || (w_done && (state_r != IDLE));
  assign clr_s      = abort_s || out_end_s;
  assign acc_en_s   = beat_s && !abort_s;

  assign next_out_idx_s = out_idx_r + OUT_ONE;

  // Column 0 including the final beat, so the first result can be registered
  // on the same edge that accepts the last activation.
  assign first_sum_s = acc_s[0] + tern_term(weights[in_idx_r][0], bus.in_data);

  for (genvar j = 0; j < MAX_OUT_LEN; j++) begin : g_col
    tt_ternary_acc u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_s),
      .en    (acc_en_s),
      .w     (weights[in_idx_r][j]),
      .x     (bus.in_data),
      .acc   (acc_s[j])
    );
  end

  // Control FSM: state, weight-ready flag, indices, length latches and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      w_ok_r      <= 1'b0;
      in_idx_r    <= IN_ZERO;
      len_in_r    <= IN_ZERO;
      out_idx_r   <= OUT_ZERO;
      len_out_r   <= OUT_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= ACC_ZERO;
    end else if (!ena) begin
      state_r     <= IDLE;
      w_ok_r      <= 1'b0;
      in_idx_r    <= IN_ZERO;
      len_in_r    <= IN_ZERO;
      out_idx_r   <= OUT_ZERO;
      len_out_r   <= OUT_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= ACC_ZERO;
    end else begin
      w_ok_r <= w_ok_r | w_done;
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          if (w_ok_r) begin
            state_r    <= ACCUM;
            in_ready_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_done) begin
            // Weights are being reloaded: drop the partial vector.
            state_r    <= ACCUM;
            in_idx_r   <= IN_ZERO;
            in_ready_r <= 1'b1;
          end else if (beat_s) begin
            if (in_idx_r == IN_ZERO) begin
              len_in_r  <= in_len_m1;
              len_out_r <= out_len_m1;
            end
            in_idx_r <= in_idx_r + IN_ONE;
            if (in_end_s) begin
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              out_idx_r   <= OUT_ZERO;
              out_valid_r <= 1'b1;
              out_data_r  <= first_sum_s;
              out_last_r  <= (len_out_s == OUT_ZERO);
            end
          end
        end
        DRAIN: begin
          if (w_done) begin
            state_r     <= ACCUM;
            in_idx_r    <= IN_ZERO;
            out_idx_r   <= OUT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end else if (out_end_s) begin
            state_r     <= ACCUM;
            in_idx_r    <= IN_ZERO;
            out_idx_r   <= OUT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end else if (out_fire_s) begin
            out_idx_r  <= next_out_idx_s;
            out_data_r <= acc_s[next_out_idx_s];
            out_last_r <= (next_out_idx_s == len_out_r);
          end
        end
        default: begin
          state_r     <= IDLE;
          in_idx_r    <= IN_ZERO;
          out_idx_r   <= OUT_ZERO;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_tt_um_matvec.sv
// Self-checking bench for tt_um_matvec: table of vectors plus hand-written
// backpressure, gapped-input, disable, reload-abort and async-reset sequences.
module tb_tt_um_matvec;
  import tt_ternary_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic w_done;
  logic [MAX_IN_LEN-1:0][MAX_OUT_LEN-1:0][1:0] weights;
  logic [IN_IDX_W-1:0]  in_len_m1;
  logic [OUT_IDX_W-1:0] out_len_m1;

  tt_um_matvec_if bus();

  tt_um_matvec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .w_done     (w_done),
    .weights    (weights),
    .in_len_m1  (in_len_m1),
    .out_len_m1 (out_len_m1),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int data; bit last; } exp_t;
  typedef struct {
    int wsel; int il; int ol; bit use_model;
    int xs[16]; int exp_y[8];
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl[5];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: each output handshake pops one expected result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("drain_in_ready_low", bus.in_ready, 0);
      check("sb_not_empty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("out_data", $signed(bus.out_data), mon_e.data);
        check("out_last", bus.out_last, mon_e.last);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_wdone();
    w_done = 1'b1;
    tick();
    w_done = 1'b0;
  endtask

  task automatic set_weights(input int sel);
    for (int i = 0; i < MAX_IN_LEN; i++)
      for (int j = 0; j < MAX_OUT_LEN; j++)
        case (sel)
          0: weights[i][j] = 2'b01;
          1: weights[i][j] = (j == 0) ? 2'b11 : (j == 1) ? 2'b00 : (j == 2) ? 2'b10 : 2'b01;
          3: weights[i][j] = (i <= j) ? 2'b01 : 2'b00;
          default: weights[i][j] = 2'($urandom_range(0, 3));
        endcase
  endtask

  // Reference dot product over the bench's own weight array
  task automatic model_push(input int il, input int ol, input int xs[16]);
    int y;
    for (int j = 0; j <= ol; j++) begin
      y = 0;
      for (int i = 0; i <= il; i++)
        if (weights[i][j] == 2'b01) y += xs[i];
        else if (weights[i][j] == 2'b11) y -= xs[i];
      sb_q.push_back(exp_t'{data: y, last: (j == ol)});
    end
  endtask

  task automatic wait_in_ready();
    int t = 0;
    while (!bus.in_ready && t < 100) begin tick(); t++; end
    check("in_ready_timeout", bus.in_ready, 1);
  endtask

  task automatic push_beat(input int x);
    bus.in_data  = x[ACT_W-1:0];
    bus.in_valid = 1'b1;
    wait_in_ready();
    tick();
  endtask

  task automatic send(input int n_m1, input int xs[16]);
    for (int i = 0; i <= n_m1; i++) push_beat(xs[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin tick(); t++; end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!bus.out_valid && t < 100) begin tick(); t++; end
    check("out_valid_timeout", bus.out_valid, 1);
  endtask

  task automatic rand_xs(output int xs[16]);
    for (int i = 0; i < 16; i++) xs[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    int xs[16];
    rst_n = 1'b0; ena = 1'b1; w_done = 1'b0; weights = '0;
    in_len_m1 = '0; out_len_m1 = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // Vector table: constants from hand calculation, random ones via the model
    tbl[0] = '{wsel: 0, il: 3, ol: 7, use_model: 1'b0, xs: '{default: 0}, exp_y: '{default: 10}};
    tbl[0].xs[0] = 1; tbl[0].xs[1] = 2; tbl[0].xs[2] = 3; tbl[0].xs[3] = 4;
    tbl[1] = '{wsel: 1, il: 15, ol: 2, use_model: 1'b0, xs: '{default: -128}, exp_y: '{default: 0}};
    tbl[1].exp_y[0] = 2048;
    tbl[2] = '{wsel: 2, il: 5, ol: 4, use_model: 1'b1, xs: '{default: 0}, exp_y: '{default: 0}};
    tbl[3] = '{wsel: 2, il: 0, ol: 0, use_model: 1'b1, xs: '{default: 0}, exp_y: '{default: 0}};
    tbl[4] = '{wsel: 2, il: 15, ol: 7, use_model: 1'b1, xs: '{default: 0}, exp_y: '{default: 0}};
    for (int k = 2; k < 5; k++) rand_xs(tbl[k].xs);
    tbl[4].xs[0] = -128; tbl[4].xs[1] = 127;

    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", $signed(bus.out_data), 0);
    tick();
    rst_n = 1'b1;

    // Activations before any w_done are not accepted
    bus.in_data = 8'sd55; bus.in_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin tick(); check("pre_wdone_in_ready", bus.in_ready, 0); end
    bus.in_valid = 1'b0;

    for (int k = 0; k < 5; k++) begin
      set_weights(tbl[k].wsel);
      pulse_wdone();
      in_len_m1 = tbl[k].il[IN_IDX_W-1:0];
      out_len_m1 = tbl[k].ol[OUT_IDX_W-1:0];
      if (tbl[k].use_model) model_push(tbl[k].il, tbl[k].ol, tbl[k].xs);
      else
        for (int j = 0; j <= tbl[k].ol; j++)
          sb_q.push_back(exp_t'{data: tbl[k].exp_y[j], last: (j == tbl[k].ol)});
      send(tbl[k].il, tbl[k].xs);
      wait_drain();
    end

    // Backpressure on the 2nd result: data and valid hold for 5 cycles
    set_weights(3); pulse_wdone();
    in_len_m1 = 4'd7; out_len_m1 = 3'd7;
    xs = '{default: 1};
    model_push(7, 7, xs);
    bus.out_ready = 1'b0;
    send(7, xs);
    wait_out_valid();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      check("bp_valid_hold", bus.out_valid, 1);
      check("bp_data_hold", $signed(bus.out_data), 2);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain();

    // Gapped input on a 2-beat vector: in_valid 1,0,0,1
    set_weights(0); pulse_wdone();
    in_len_m1 = 4'd1; out_len_m1 = 3'd1;
    sb_q.push_back(exp_t'{data: 30, last: 1'b0});
    sb_q.push_back(exp_t'{data: 30, last: 1'b1});
    wait_in_ready();
    bus.in_data = 8'sd10; bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; bus.in_data = 8'sd100; tick(); tick();
    check("gap_no_early_valid", bus.out_valid, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'sd20; tick();
    bus.in_valid = 1'b0;
    check("gap_first_result_latency", bus.out_valid, 1);
    wait_drain();

    // ena low in the middle of a drain, then an exact fresh vector
    set_weights(2); pulse_wdone();
    in_len_m1 = 4'd3; out_len_m1 = 3'd7;
    rand_xs(xs);
    model_push(3, 7, xs);
    bus.out_ready = 1'b0;
    send(3, xs);
    wait_out_valid();
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    bus.out_ready = 1'b0;
    check("ena_drain_idx3_data", $signed(bus.out_data), sb_q[0].data);
    ena = 1'b0;
    sb_q.delete();
    tick();
    check("ena_off_out_valid", bus.out_valid, 0);
    check("ena_off_in_ready", bus.in_ready, 0);
    check("ena_off_out_last", bus.out_last, 0);
    ena = 1'b1; bus.out_ready = 1'b1;
    tick(); tick();
    check("ena_on_wok_cleared", bus.in_ready, 0);
    pulse_wdone();
    rand_xs(xs);
    model_push(3, 7, xs);
    send(3, xs);
    wait_drain();

    // w_done mid-vector discards the partial sums
    in_len_m1 = 4'd3; out_len_m1 = 3'd3;
    push_beat(100); push_beat(-77);
    bus.in_valid = 1'b0;
    set_weights(2); pulse_wdone();
    rand_xs(xs);
    model_push(3, 3, xs);
    send(3, xs);
    wait_drain();

    // Asynchronous reset mid-accumulation
    in_len_m1 = 4'd3; out_len_m1 = 3'd5;
    push_beat(50); push_beat(60);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", bus.in_ready, 0);
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_out_data", $signed(bus.out_data), 0);
    check("async_rst_out_last", bus.out_last, 0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_wdone();
    rand_xs(xs);
    model_push(3, 5, xs);
    send(3, xs);
    wait_drain();

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
